contador_ctrl: RTL

- Sequencing controller for the team's WIDTH-bit counter datapath. Loads a start value, then counts up or down at a prescaled rate.
- Flags terminal count and either stops (one-shot) or reloads (periodic). Supports pause/resume and abort.
- Sits between control logic and the counter value consumers; it embeds the counter register, so q is the counter output.

---
 rtl/contador_ctrl.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/contador_ctrl.sv
// contador_ctrl
//   Sequencing controller with an embedded WIDTH-bit counter register.
//   A start request latches load_val/dir/auto_reload into shadow registers,
//   spends one LOAD cycle copying the shadow value into the counter, then
//   counts up or down once every PRESCALE clocks. Reaching the terminal
//   value (all-ones up, zero down) produces a one-cycle tc pulse, followed
//   by either a reload (periodic) or a stop in DONE (one-shot).
//
// Ports
//   clk          rising-edge clock
//   clr          asynchronous active-low reset
//   start        start request, honoured only in IDLE or DONE
//   pause        level; freezes counting (RUN -> HOLD)
//   abort        synchronous return to IDLE, highest synchronous priority
//   dir          1 = up, 0 = down (sampled on accepted start)
//   auto_reload  1 = periodic, 0 = one-shot (sampled on accepted start)
//   load_val     start value (sampled on accepted start)
//   q            current count
//   busy         high in LOAD, RUN, HOLD
//   tc           registered terminal-count pulse
//   done         high while in DONE
module contador_ctrl #(
    parameter int WIDTH    = 4,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic             pause,
    input  logic             abort,
    input  logic             dir,
    input  logic             auto_reload,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             tc,
    output logic             done
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_HOLD,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [PW-1:0]    ps_q, ps_d;
    logic [WIDTH-1:0] sh_val_q, sh_val_d;
    logic             sh_dir_q, sh_dir_d;
    logic             sh_ar_q, sh_ar_d;
    logic             tc_q, tc_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] terminal;
    logic             at_term;
    logic             ps_tick;

    // Terminal depends on the latched direction, never on the live dir pin.
    assign terminal = sh_dir_q ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
    assign at_term  = (cnt_q == terminal);
    assign ps_tick  = (ps_q == PS_LAST);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ps_d     = ps_q;
        sh_val_d = sh_val_q;
        sh_dir_d = sh_dir_q;
        sh_ar_d  = sh_ar_q;
        tc_d     = 1'b0;

        if (abort) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            ps_d    = '0;
        end else begin
            unique case (state_q)
                S_IDLE, S_DONE: begin
                    // pause is irrelevant here; it only bites once RUN is reached
                    if (start) begin
                        state_d  = S_LOAD;
                        sh_val_d = load_val;
                        sh_dir_d = dir;
                        sh_ar_d  = auto_reload;
                    end
                end
                S_LOAD: begin
                    cnt_d   = sh_val_q;
                    ps_d    = '0;
                    state_d = S_RUN;
                end
                S_RUN: begin
                    if (pause) begin
                        // enter HOLD without consuming this cycle's tick
                        state_d = S_HOLD;
                    end else if (ps_tick) begin
                        ps_d = '0;
                        if (at_term) begin
                            // terminal replaces wrap-around: reload or stop
                            tc_d = 1'b1;
                            if (sh_ar_q) cnt_d   = sh_val_q;
                            else         state_d = S_DONE;
                        end else if (sh_dir_q) begin
                            cnt_d = cnt_q + WIDTH'(1);
                        end else begin
                            cnt_d = cnt_q - WIDTH'(1);
                        end
                    end else begin
                        ps_d = ps_q + PW'(1);
                    end
                end
                S_HOLD: begin
                    // prescaler phase is kept, so resume continues mid-interval
                    if (!pause) state_d = S_RUN;
                end
                default: state_d = S_IDLE;
            endcase
        end

        busy_d = (state_d == S_LOAD) || (state_d == S_RUN) || (state_d == S_HOLD);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            ps_q     <= '0;
            sh_val_q <= '0;
            sh_dir_q <= 1'b0;
            sh_ar_q  <= 1'b0;
            tc_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ps_q     <= ps_d;
            sh_val_q <= sh_val_d;
            sh_dir_q <= sh_dir_d;
            sh_ar_q  <= sh_ar_d;
            tc_q     <= tc_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign q    = cnt_q;
    assign busy = busy_q;
    assign tc   = tc_q;
    assign done = done_q;

endmodule
